// File: rtl/lsu_ctrl.sv
// lsu_ctrl: registered load/store engine for the MEM stage.
// Steers each access to the data cache or the uncached device bus by address,
// builds byte strobes and lane-shifted store data, and sign/zero-extends loads.
module lsu_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter logic [31:0] CACHE_BASE  = 32'h8000_0000,
    parameter logic [31:0] CACHE_LIMIT = 32'h87ff_ffff,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_wen,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    output logic                    o_resp_valid,
    output logic [DATA_WIDTH-1:0]   o_resp_rdata,
    output logic                    o_resp_err,
    output logic                    o_dc_req,
    output logic                    o_dc_wen,
    output logic [31:0]             o_dc_addr,
    output logic [DATA_WIDTH-1:0]   o_dc_wdata,
    output logic [DATA_WIDTH/8-1:0] o_dc_wmask,
    input  logic [DATA_WIDTH-1:0]   i_dc_rdata,
    input  logic                    i_dc_done,
    output logic                    o_io_valid,
    input  logic                    i_io_ready,
    output logic                    o_io_wen,
    output logic [31:0]             o_io_addr,
    output logic [DATA_WIDTH-1:0]   o_io_wdata,
    output logic [DATA_WIDTH/8-1:0] o_io_wstrb,
    input  logic                    i_io_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_io_rsp_rdata,
    input  logic                    i_io_rsp_err
);

    localparam int unsigned   STRB = DATA_WIDTH / 8;
    localparam int unsigned   OFFW = $clog2(STRB);
    localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_CACHE, S_IO_REQ, S_IO_RSP, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_wen;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [OFFW-1:0]       r_off;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB-1:0]       r_strb;
    logic [DATA_WIDTH-1:0] r_raw;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;

    // Request decode: only the low 32 address bits take part in steering.
    logic [31:0]           w_addr32;
    logic [OFFW-1:0]       w_off;
    logic                  w_misalign;
    logic                  w_illegal;
    logic                  w_bad;
    logic                  w_cacheable;
    logic [STRB-1:0]       w_lanes;
    logic [STRB-1:0]       w_strb;
    logic [DATA_WIDTH-1:0] w_wdata_sh;
    logic [31:0]           w_addr_al;
    logic                  w_unused_addr;

    assign w_addr32      = i_req_addr[31:0];
    assign w_off         = i_req_addr[OFFW-1:0];
    assign w_misalign    = (i_req_size == 2'd1) ? i_req_addr[0] :
                           (i_req_size == 2'd2) ? |i_req_addr[1:0] :
                           (i_req_size == 2'd3) ? |i_req_addr[2:0] : 1'b0;
    assign w_illegal     = (i_req_size == 2'd3) && (DATA_WIDTH == 32);
    assign w_bad         = w_misalign || w_illegal;
    assign w_cacheable   = (w_addr32 >= CACHE_BASE) && (w_addr32 <= CACHE_LIMIT);
    assign w_lanes       = ~({STRB{1'b1}} << (4'd1 << i_req_size));
    assign w_strb        = w_lanes << w_off;
    assign w_wdata_sh    = i_req_wdata << {w_off, 3'b000};
    assign w_addr_al     = {w_addr32[31:OFFW], {OFFW{1'b0}}};
    assign w_unused_addr = ^i_req_addr;

    // Load return path: shift the captured bus word down, keep 2^size bytes,
    // then fill the upper bits with the top kept bit or with zeros.
    logic [DATA_WIDTH-1:0] w_rshift;
    logic [6:0]            w_nbits;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_rshift = r_raw >> {r_off, 3'b000};
    assign w_nbits  = 7'd8 << r_size;
    assign w_mask   = ~({DATA_WIDTH{1'b1}} << w_nbits);
    assign w_sign   = ~r_unsigned & |(w_rshift & w_mask & ~(w_mask >> 1));
    assign w_ext    = (w_rshift & w_mask) | ({DATA_WIDTH{w_sign}} & ~w_mask);

    // State register; reset abandons any access in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; stray dc_done / io_rsp_valid outside their states are ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (w_bad)            w_next = S_RESP;
                    else if (w_cacheable) w_next = S_CACHE;
                    else                  w_next = S_IO_REQ;
                end
            end
            S_CACHE:  if (i_dc_done) w_next = S_RESP;
            S_IO_REQ: if (i_io_ready) w_next = S_IO_RSP;
            S_IO_RSP: if (i_io_rsp_valid || (r_cnt == TMAX)) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request latch, response capture and device-response timeout counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wen      <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_off      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_raw      <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_wen      <= i_req_wen;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_off      <= w_off;
                        r_addr     <= w_addr_al;
                        r_wdata    <= w_wdata_sh;
                        r_strb     <= w_strb;
                        r_raw      <= '0;
                        r_err      <= w_bad;
                    end
                end
                S_CACHE: begin
                    if (i_dc_done) r_raw <= i_dc_rdata;
                end
                S_IO_REQ: begin
                    if (i_io_ready) r_cnt <= '0;
                end
                S_IO_RSP: begin
                    if (i_io_rsp_valid) begin
                        r_raw <= i_io_rsp_rdata;
                        r_err <= i_io_rsp_err;
                    end else if (r_cnt == TMAX) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state; downstream fields are zero while idle.
    always_comb begin
        o_req_ready  = (r_state == S_IDLE) && !i_rst;
        o_resp_valid = (r_state == S_RESP);
        o_resp_err   = (r_state == S_RESP) && r_err;
        o_resp_rdata = '0;
        if ((r_state == S_RESP) && !r_err && !r_wen) o_resp_rdata = w_ext;
        o_dc_req   = (r_state == S_CACHE);
        o_dc_wen   = 1'b0;
        o_dc_addr  = '0;
        o_dc_wdata = '0;
        o_dc_wmask = '0;
        if (r_state == S_CACHE) begin
            o_dc_wen   = r_wen;
            o_dc_addr  = r_addr;
            o_dc_wdata = r_wdata;
            o_dc_wmask = r_strb;
        end
        o_io_valid = (r_state == S_IO_REQ);
        o_io_wen   = 1'b0;
        o_io_addr  = '0;
        o_io_wdata = '0;
        o_io_wstrb = '0;
        if (r_state == S_IO_REQ) begin
            o_io_wen   = r_wen;
            o_io_addr  = r_addr;
            o_io_wdata = r_wdata;
            o_io_wstrb = r_strb;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a
// byte-arithmetic reference model of addressing, strobes and load extension.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWen = 1'b0;
    logic [63:0] reqAddr = '0;
    logic [63:0] reqWdata = '0;
    logic [1:0]  reqSize = '0;
    logic        reqUnsigned = 1'b0;
    logic        respValid;
    logic [63:0] respRdata;
    logic        respErr;
    logic        dcReq;
    logic        dcWen;
    logic [31:0] dcAddr;
    logic [63:0] dcWdata;
    logic [7:0]  dcWmask;
    logic [63:0] dcRdata = '0;
    logic        dcDone = 1'b0;
    logic        ioValid;
    logic        ioReady = 1'b0;
    logic        ioWen;
    logic [31:0] ioAddr;
    logic [63:0] ioWdata;
    logic [7:0]  ioWstrb;
    logic        ioRspValid = 1'b0;
    logic [63:0] ioRspRdata = '0;
    logic        ioRspErr = 1'b0;

    int checks = 0;
    int failures = 0;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_wen(reqWen),
        .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .i_req_size(reqSize),
        .i_req_unsigned(reqUnsigned),
        .o_resp_valid(respValid), .o_resp_rdata(respRdata), .o_resp_err(respErr),
        .o_dc_req(dcReq), .o_dc_wen(dcWen), .o_dc_addr(dcAddr), .o_dc_wdata(dcWdata),
        .o_dc_wmask(dcWmask), .i_dc_rdata(dcRdata), .i_dc_done(dcDone),
        .o_io_valid(ioValid), .i_io_ready(ioReady), .o_io_wen(ioWen), .o_io_addr(ioAddr),
        .o_io_wdata(ioWdata), .o_io_wstrb(ioWstrb),
        .i_io_rsp_valid(ioRspValid), .i_io_rsp_rdata(ioRspRdata), .i_io_rsp_err(ioRspErr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison point: count it, and report it when it differs.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Reference load result: take 2^size bytes starting at byte 'off' of the bus
    // word and widen them as a signed or unsigned integer to 64 bits.
    function automatic logic [63:0] modelLoad(input logic [63:0] raw, input int size,
                                              input int off, input bit uns);
        int          nb;
        logic [63:0] v;
        nb = 8 << size;
        v  = raw >> (8 * off);
        if (nb < 64) begin
            v = v % (64'd1 << nb);
            if (!uns && (v >= (64'd1 << (nb - 1)))) v = v - (64'd1 << nb);
        end
        return v;
    endfunction

    // Drive one access and play the role of cache or device; every cycle until the
    // response is checked against the expected path, fields and timing.
    // rspDly < 0 means the device never answers.
    task automatic applyStimulus(input string tag, input bit wen, input logic [63:0] addr,
                                 input logic [63:0] wdata, input int size, input bit uns,
                                 input logic [63:0] raw, input bit ioErr,
                                 input int rdyDly, input int rspDly, input int doneDly);
        int          bytes;
        int          off;
        bit          bad;
        bit          cached;
        bit          expErr;
        logic [31:0] a32;
        logic [31:0] expAddr;
        logic [7:0]  expStrb;
        logic [63:0] expData;
        logic [63:0] expRdata;
        bytes   = 1 << size;
        a32     = addr[31:0];
        off     = int'(a32 % 8);
        bad     = (a32 % bytes) != 0;
        cached  = (a32 >= 32'h8000_0000) && (a32 <= 32'h87FF_FFFF);
        expStrb = 8'(((1 << bytes) - 1) << off);
        expData = wdata << (8 * off);
        expAddr = a32 - (a32 % 8);
        expErr  = 1'b0;

        checkOutput({tag, ".ready"}, 64'(reqReady), 64'd1);
        reqValid    = 1'b1;
        reqWen      = wen;
        reqAddr     = addr;
        reqWdata    = wdata;
        reqSize     = 2'(size);
        reqUnsigned = uns;
        tick();
        reqValid = 1'b0;
        reqWdata = 64'( 64'($urandom) << 32 | 64'($urandom));
        checkOutput({tag, ".busy"}, 64'(reqReady), 64'd0);

        if (bad) begin
            expErr = 1'b1;
            checkOutput({tag, ".noaccess"}, {62'd0, dcReq, ioValid}, 64'd0);
        end else if (cached) begin
            for (int k = 0; k <= doneDly; k++) begin
                checkOutput({tag, ".dcreq"}, {61'd0, dcReq, ioValid, respValid}, 64'd4);
                checkOutput({tag, ".dcwen"}, 64'(dcWen), 64'(wen));
                checkOutput({tag, ".dcaddr"}, 64'(dcAddr), 64'(expAddr));
                checkOutput({tag, ".dcwmask"}, 64'(dcWmask), 64'(expStrb));
                checkOutput({tag, ".dcwdata"}, dcWdata, expData);
                if (k == doneDly) begin
                    dcDone  = 1'b1;
                    dcRdata = raw;
                end
                tick();
                dcDone = 1'b0;
            end
        end else begin
            for (int k = 0; k <= rdyDly; k++) begin
                checkOutput({tag, ".iovalid"}, {61'd0, dcReq, ioValid, respValid}, 64'd2);
                checkOutput({tag, ".iowen"}, 64'(ioWen), 64'(wen));
                checkOutput({tag, ".ioaddr"}, 64'(ioAddr), 64'(expAddr));
                checkOutput({tag, ".iowstrb"}, 64'(ioWstrb), 64'(expStrb));
                checkOutput({tag, ".iowdata"}, ioWdata, expData);
                ioReady = (k == rdyDly);
                tick();
                ioReady = 1'b0;
            end
            if (rspDly < 0) begin
                for (int k = 0; k <= TIMEOUT; k++) begin
                    checkOutput({tag, ".waitrsp"}, {61'd0, dcReq, ioValid, respValid}, 64'd0);
                    tick();
                end
                expErr = 1'b1;
            end else begin
                for (int k = 0; k <= rspDly; k++) begin
                    checkOutput({tag, ".waitrsp"}, {61'd0, dcReq, ioValid, respValid}, 64'd0);
                    if (k == rspDly) begin
                        ioRspValid = 1'b1;
                        ioRspRdata = raw;
                        ioRspErr   = ioErr;
                    end
                    tick();
                    ioRspValid = 1'b0;
                    ioRspErr   = 1'b0;
                end
                expErr = ioErr;
            end
        end

        expRdata = (wen || expErr) ? 64'd0 : modelLoad(raw, size, off, uns);
        checkOutput({tag, ".respvalid"}, 64'(respValid), 64'd1);
        checkOutput({tag, ".resperr"}, 64'(respErr), 64'(expErr));
        checkOutput({tag, ".resprdata"}, respRdata, expRdata);
        checkOutput({tag, ".respready"}, 64'(reqReady), 64'd0);
        tick();
        checkOutput({tag, ".pulse"}, {62'd0, respValid, reqReady}, 64'd1);
    endtask

    // Directed steps first, then randomized traffic, then the summary line.
    initial begin
        $display("[TB] start");
        tick();
        checkOutput("rst.ready", 64'(reqReady), 64'd0);
        checkOutput("rst.outs", {60'd0, respValid, respErr, dcReq, ioValid}, 64'd0);
        checkOutput("rst.fields", 64'(dcAddr) | 64'(ioAddr) | dcWdata | ioWdata | respRdata, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst.release", 64'(reqReady), 64'd1);
        tick();

        applyStimulus("lw_cache", 1'b0, 64'h0000_0000_8000_0004, 64'd0, 2, 1'b0,
                      64'h8000_0001_0000_0000, 1'b0, 0, 0, 0);
        applyStimulus("sb_cache", 1'b1, 64'h0000_0000_8000_0003, 64'hAB, 0, 1'b0,
                      64'h1234_5678_9ABC_DEF0, 1'b0, 0, 0, 2);
        applyStimulus("lhu_io", 1'b0, 64'h0000_0000_A000_0006, 64'd0, 1, 1'b1,
                      64'hFEDC_0000_0000_0000, 1'b0, 3, 1, 0);
        applyStimulus("io_t4", 1'b0, 64'h0000_0000_A000_0000, 64'd0, 0, 1'b0,
                      64'h0000_0000_0000_0080, 1'b0, 1, 0, 0);
        applyStimulus("lw_mis", 1'b0, 64'h0000_0000_8000_0002, 64'd0, 2, 1'b0,
                      64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 0);
        applyStimulus("ld_base", 1'b0, 64'hFFFF_0000_8000_0000, 64'd0, 3, 1'b0,
                      64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0, 0, 0);
        applyStimulus("ld_limit", 1'b0, 64'h0000_0000_87FF_FFF8, 64'd0, 3, 1'b0,
                      64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 1);
        applyStimulus("ld_above", 1'b0, 64'h0000_0000_8800_0000, 64'd0, 3, 1'b0,
                      64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 0, 0, 0);
        applyStimulus("ld_below", 1'b0, 64'h0000_0000_7FFF_FFF8, 64'd0, 3, 1'b0,
                      64'h1111_2222_3333_4444, 1'b0, 0, 0, 0);
        applyStimulus("io_buserr", 1'b0, 64'h0000_0000_A000_0010, 64'd0, 2, 1'b0,
                      64'h5555_5555_5555_5555, 1'b1, 0, 2, 0);
        applyStimulus("io_timeout", 1'b0, 64'h0000_0000_A000_0020, 64'd0, 2, 1'b0,
                      64'h0, 1'b0, 0, -1, 0);

        // A device answer arriving after the timeout must not create a response.
        ioRspValid = 1'b1;
        ioRspRdata = 64'hFFFF_FFFF_FFFF_FFFF;
        dcDone     = 1'b1;
        tick();
        ioRspValid = 1'b0;
        dcDone     = 1'b0;
        checkOutput("late.resp", {62'd0, respValid, reqReady}, 64'd1);
        tick();
        checkOutput("late.resp2", {62'd0, respValid, reqReady}, 64'd1);

        // Reset while waiting on the cache abandons the access silently.
        reqValid = 1'b1;
        reqWen   = 1'b0;
        reqAddr  = 64'h0000_0000_8000_0010;
        reqSize  = 2'd3;
        tick();
        reqValid = 1'b0;
        tick();
        checkOutput("mid.dcreq", 64'(dcReq), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid.outs", {60'd0, reqReady, respValid, dcReq, ioValid}, 64'd0);
        checkOutput("mid.fields", 64'(dcAddr) | 64'(dcWmask), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mid.ready", 64'(reqReady), 64'd1);
        tick();
        checkOutput("mid.noresp", {62'd0, respValid, reqReady}, 64'd1);
        applyStimulus("mid.ld", 1'b0, 64'h0000_0000_8000_0010, 64'd0, 3, 1'b0,
                      64'hA5A5_5A5A_0000_FFFF, 1'b0, 0, 0, 0);

        // Randomized mix of loads/stores, sizes, regions, alignment and delays.
        for (int n = 0; n < 40; n++) begin
            int          sz;
            int          low;
            logic [31:0] a32;
            logic [63:0] wd;
            logic [63:0] rw;
            sz  = $urandom_range(0, 3);
            low = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) low = low & ~((1 << sz) - 1);
            if ($urandom_range(0, 1) == 1) a32 = 32'h8000_0000 + ($urandom & 32'h07FF_FFF8);
            else                           a32 = 32'hA000_0000 + ($urandom & 32'h0FFF_FFF8);
            a32 = a32 + 32'(low);
            wd  = {32'($urandom), 32'($urandom)};
            rw  = {32'($urandom), 32'($urandom)};
            applyStimulus("rand", 1'($urandom_range(0, 1)), {32'($urandom), a32}, wd, sz,
                          1'($urandom_range(0, 1)), rw, ($urandom_range(0, 4) == 0),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
